// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: sequences loads/stores over a req/ack port,
// builds byte enables and lane-replicated store data, and extends load data.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memwrite_m,
    input  logic [1:0]            resultsrc_m,
    input  logic [2:0]            funct3_m,
    input  logic [31:0]           aluresult_m,
    input  logic [DATA_WIDTH-1:0] writedata_m,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  stall_m,
    output logic [DATA_WIDTH-1:0] readdata_m,
    output logic                  misalign_m,
    output logic                  bus_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;

    logic             access, is_byte, is_half, misaligned;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // Size decode: funct3[1:0] picks b/h; every other encoding behaves as a word.
    always_comb begin
        access     = memwrite_m | (resultsrc_m == 2'b01);
        is_byte    = (funct3_m[1:0] == 2'b00);
        is_half    = (funct3_m[1:0] == 2'b01);
        misaligned = is_half ? aluresult_m[0] : (!is_byte && (aluresult_m[1:0] != 2'b00));
        misalign_m = access & misaligned;
        if (is_byte) begin
            be_c    = 4'b0001 << aluresult_m[1:0];
            wdata_c = {4{writedata_m[7:0]}};
        end else if (is_half) begin
            be_c    = aluresult_m[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{writedata_m[15:0]}};
        end else begin
            be_c    = 4'b1111;
            wdata_c = writedata_m;
        end
    end

    always_comb begin
        state_next = state;
        stall_m    = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    stall_m    = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                stall_m = 1'b1;
                if (mem_ack || (cnt == CNT_MAX)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            readdata_m <= '0;
            bus_err    <= 1'b0;
            cnt        <= '0;
            off_q      <= '0;
            f3_q       <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (misalign_m) begin
                        readdata_m <= '0;
                    end else if (access) begin
                        mem_req   <= 1'b1;
                        mem_we    <= memwrite_m;
                        mem_addr  <= {aluresult_m[31:2], 2'b00};
                        mem_be    <= be_c;
                        mem_wdata <= wdata_c;
                        cnt       <= '0;
                        off_q     <= aluresult_m[1:0];
                        f3_q      <= funct3_m;
                    end
                end
                BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        readdata_m <= load_ext(f3_q, off_q, mem_rdata);
                    end else if (cnt == CNT_MAX) begin
                        mem_req    <= 1'b0;
                        readdata_m <= '0;
                        bus_err    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller for the pipelined RV32I core. Sits between the EX/MEM pipeline register outputs and a variable-latency data-memory port. Sequences each load/store through a req/ack handshake, generates byte enables and store-data lane replication, and sign/zero-extends load data. Holds a global stall while an access is outstanding so every pipeline register freezes until the access completes.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width (only 32 supported)
- TIMEOUT_CYCLES, 16, max BUSY cycles waiting for ack before bus error (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- memwrite_m  in  1  store in MEM stage
- resultsrc_m  in  2  2'b01 = load in MEM stage
- funct3_m  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
- aluresult_m  in  32  byte address
- writedata_m  in  32  store data (unaligned lanes)
- mem_req  out  1  request valid, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  completion; rdata valid same cycle
- mem_rdata  in  32  read word
- stall_m  out  1  freeze PC and all pipeline registers
- readdata_m  out  32  extended load result, valid in DONE
- misalign_m  out  1  misaligned access detected (comb.)
- bus_err  out  1  one-cycle pulse on timeout

## Operation
- access = memwrite_m | (resultsrc_m == 2'b01). Misaligned: w with addr[1:0]≠0; h/hu with addr[0]=1. misalign_m = access & misaligned, combinational.
- FSM states IDLE, BUSY, DONE.
- IDLE: access & !misaligned → stall_m=1, register mem_addr/mem_we/mem_be/mem_wdata, mem_req<=1, clear timeout counter, go BUSY. Misaligned access: no request, no stall, readdata_m=0, store suppressed, stay IDLE. mem_ack in IDLE ignored.
- BUSY: stall_m=1; mem_req and all request fields stable. mem_ack=1 → capture extended mem_rdata into readdata register, mem_req<=0, go DONE. Else counter++; counter reaching TIMEOUT_CYCLES-1 without ack → mem_req<=0, readdata<=0, bus_err<=1 for one cycle, go DONE.
- DONE: stall_m=0, readdata_m valid; pipeline advances; go IDLE unconditionally (current access never reissued).
- Byte enables: b → 4'b0001<<addr[1:0]; h → addr[1]?1100:0011; w → 1111. Applied to loads and stores.
- Store data: b → {4{wd[7:0]}}; h → {2{wd[15:0]}}; w → wd.
- Load extend: select byte/half by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passthrough. Unlisted funct3 treated as w.

## Timing
- Reset: state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, readdata_m=0, bus_err=0, counter=0; stall_m=0 after reset.
- Access presented cycle 0: stall_m=1 cycle 0; mem_req=1 from cycle 1. Ack in cycle k≥1 → DONE in cycle k+1, stall_m=0, pipeline advances at end of k+1. Zero-wait memory: 3 cycles per access, 2 stall cycles.
- Back-to-back accesses: next access enters MEM at cycle k+2, restarts from IDLE.
- Timeout: no ack in cycles 1..TIMEOUT_CYCLES → bus_err high in DONE cycle TIMEOUT_CYCLES+1.
- Ack in same cycle as timeout threshold: ack wins, no bus_err.
- rst in any state: next cycle IDLE, mem_req=0, stall_m=0; in-flight ack discarded.
- stall_m combinational from state and access; no other output combinational except misalign_m.

## Test plan
- lw addr 0x100, ack in cycle 1 with rdata 0xDEADBEEF → mem_addr 0x100, be 1111, stall cycles 0–1, readdata_m 0xDEADBEEF in cycle 2.
- lb addr 0x103, rdata 0x80FF_0000 → be 1000, readdata_m 0xFFFFFF80; lbu same → 0x00000080; lhu addr 0x102 → 0x000080FF.
- sb addr 0x201, writedata 0x12345678, ack after 4 cycles → mem_we=1, be 0010, wdata 0x78787878, req held 4 cycles unchanged, stall released cycle after ack.
- sw addr 0x202 → misalign_m=1, mem_req stays 0, stall_m=0.
- TIMEOUT_CYCLES=16, never ack → req drops, bus_err pulse in cycle 17, readdata_m=0, FSM returns IDLE.
- rst asserted in BUSY cycle 2 with ack arriving cycle 3 → mem_req=0 cycle 3, state IDLE, ack ignored, stall_m=0.
